// File: rtl/adder_tree_pkg.sv
// Shared constants and helpers for the pipelined adder tree.
// Provides clog2, the full-precision width derivation and a signed clamp.
package adder_tree_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width of the exact sum of n operands of dw bits each.
    function automatic int full_w(input int dw, input int n);
        return dw + clog2(n);
    endfunction

    // Clamp v into the signed range of a w-bit value; hit flags a clamp.
    function automatic longint saturate(
        input  longint v,
        input  int     w,
        output logic   hit
    );
        longint hi;
        longint lo;
        hi  = (longint'(1) <<< (w - 1)) - 1;
        lo  = -hi - 1;
        hit = 1'b0;
        saturate = v;
        if (v > hi) begin
            saturate = hi;
            hit      = 1'b1;
        end else if (v < lo) begin
            saturate = lo;
            hit      = 1'b1;
        end
    endfunction

endpackage

// File: rtl/adder_tree_pipe_if.sv
// Operand/result bundle of the adder tree.
// master drives enable/clear/data_in, slave returns output1/done/sat_flag.
interface adder_tree_pipe_if
    import adder_tree_pkg::*;
#(
    parameter int DATA_W = 21,
    parameter int NUM_IN = 8
) ();
    localparam int FULL_W = full_w(DATA_W, NUM_IN);

    logic                     enable;
    logic                     clear;
    logic [NUM_IN*DATA_W-1:0] data_in;
    logic [FULL_W-1:0]        output1;
    logic                     done;
    logic                     sat_flag;

    modport master (
        output enable, clear, data_in,
        input  output1, done, sat_flag
    );

    modport slave (
        input  enable, clear, data_in,
        output output1, done, sat_flag
    );
endinterface

// File: rtl/adder_tree_level.sv
// One registered level of the reduction tree: N operands -> N/2 sums.
// Ports: clk, rst_n, clear_i, vld_i, data_i -> vld_o, data_o, sat_o.
// ADDER_TREE_SAT_EN enables clamping on the LAST level only.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int N     = 2,
    parameter int IN_W  = 21,
    parameter bit LAST  = 1'b0,
    parameter int SAT_W = 22,
    localparam int OUT_W = IN_W + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     vld_i,
    input  logic [N*IN_W-1:0]        data_i,
    output logic                     vld_o,
    output logic [(N/2)*OUT_W-1:0]   data_o,
    output logic                     sat_o
);
    logic [(N/2)*OUT_W-1:0] sum_d, sum_q;
    logic                   sat_d, sat_q;
    logic                   vld_q;

    always_comb begin
        logic [IN_W-1:0]  a;
        logic [IN_W-1:0]  b;
        logic [OUT_W-1:0] s;
        longint           cl;
        logic             hit;
        sum_d = '0;
        sat_d = 1'b0;
        a     = '0;
        b     = '0;
        s     = '0;
        cl    = 0;
        hit   = 1'b0;
        for (int j = 0; j < N / 2; j++) begin
            a = data_i[(2*j)*IN_W +: IN_W];
            b = data_i[(2*j+1)*IN_W +: IN_W];
            // One guard bit on each operand: the sum can never wrap.
            s = {a[IN_W-1], a} + {b[IN_W-1], b};
`ifdef ADDER_TREE_SAT_EN
            if (LAST) begin
                cl    = saturate(longint'($signed(s)), SAT_W, hit);
                s     = cl[OUT_W-1:0];
                sat_d = sat_d | hit;
            end
`endif
            sum_d[j*OUT_W +: OUT_W] = s;
        end
    end

    // An idle slot loads zeros so the result is 0 whenever not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            vld_q <= 1'b0;
            sat_q <= 1'b0;
        end else if (clear_i || !vld_i) begin
            sum_q <= '0;
            vld_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            vld_q <= 1'b1;
            sat_q <= sat_d;
        end
    end

    assign data_o = sum_q;
    assign vld_o  = vld_q;
`ifdef ADDER_TREE_SAT_EN
    assign sat_o  = sat_q;
`else
    assign sat_o  = 1'b0;
`endif

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: NUM_IN operands summed in log2(NUM_IN)
// registered levels, one set per cycle. Ports: clk, rst_n, bus (slave).
// Define ADDER_TREE_SAT_EN to clamp output1 to SAT_W bits with sat_flag.
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int DATA_W = 21,
    parameter int NUM_IN = 8,
    parameter int SAT_W  = 22
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_tree_pipe_if.slave   bus
);
    localparam int LVL    = clog2(NUM_IN);
    localparam int FULL_W = full_w(DATA_W, NUM_IN);

    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        localparam int N     = NUM_IN >> k;
        localparam int IN_W  = DATA_W + k;
        localparam int OUT_W = IN_W + 1;

        logic [N*IN_W-1:0]        din;
        logic                     vin;
        logic [(N/2)*OUT_W-1:0]   dout;
        logic                     vout;
        logic                     sat;

        if (k == 0) begin : g_first
            assign din = bus.data_in;
            assign vin = bus.enable;
        end else begin : g_next
            assign din = g_lvl[k-1].dout;
            assign vin = g_lvl[k-1].vout;
        end

        adder_tree_level #(
            .N     (N),
            .IN_W  (IN_W),
            .LAST  (k == LVL - 1),
            .SAT_W (SAT_W)
        ) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear_i (bus.clear),
            .vld_i   (vin),
            .data_i  (din),
            .vld_o   (vout),
            .data_o  (dout),
            .sat_o   (sat)
        );
    end

    assign bus.output1  = g_lvl[LVL-1].dout[FULL_W-1:0];
    assign bus.done     = g_lvl[LVL-1].vout;
    assign bus.sat_flag = g_lvl[LVL-1].sat;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe (DATA_W=21, NUM_IN=8).
// Table vectors, hand sequences and random traffic vs. a cycle-indexed model.
module tb_adder_tree_pipe;
    localparam int DATA_W = 21;
    localparam int NUM_IN = 8;
    localparam int SAT_W  = 22;
    localparam int LVL    = 3;
    localparam int DW     = NUM_IN * DATA_W;

    logic clk;
    logic rst_n;

    adder_tree_pipe_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN)) bus ();

    adder_tree_pipe #(
        .DATA_W (DATA_W),
        .NUM_IN (NUM_IN),
        .SAT_W  (SAT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int cyc;

    // Expected output after edge number t.
    bit     sv [0:8191];
    longint ss [0:8191];
    bit     sf [0:8191];

    typedef struct {
        string  name;
        int     ops [NUM_IN];
        longint exp;
        bit     sat;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pack(input int ops [NUM_IN]);
        logic [DW-1:0] d;
        int            v;
        d = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            v = ops[i];
            d[i*DATA_W +: DATA_W] = v[DATA_W-1:0];
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] fill(input int v);
        int ops [NUM_IN];
        for (int i = 0; i < NUM_IN; i++) ops[i] = v;
        return pack(ops);
    endfunction

    // Plain integer reference: add the signed operands, then clamp.
    task automatic ref_sum(input logic [DW-1:0] d,
                           output longint s, output bit f);
        longint hi;
        longint lo;
        s = 0;
        f = 1'b0;
        for (int i = 0; i < NUM_IN; i++)
            s += longint'($signed(d[i*DATA_W +: DATA_W]));
`ifdef ADDER_TREE_SAT_EN
        hi = (longint'(1) <<< (SAT_W - 1)) - 1;
        lo = -(longint'(1) <<< (SAT_W - 1));
        if (s > hi) begin s = hi; f = 1'b1; end
        else if (s < lo) begin s = lo; f = 1'b1; end
`else
        hi = 0;
        lo = 0;
`endif
    endtask

    task automatic check_out(input string tag);
        longint es;
        es = sv[cyc] ? ss[cyc] : 0;
        chk({tag, ".done"}, longint'(bus.done), longint'(sv[cyc]));
        chk({tag, ".out"}, longint'($signed(bus.output1)), es);
        chk({tag, ".sat"}, longint'(bus.sat_flag),
            sv[cyc] ? longint'(sf[cyc]) : 0);
    endtask

    task automatic step(input bit en, input bit clr,
                        input logic [DW-1:0] d);
        longint s;
        bit     f;
        bus.enable  = en;
        bus.clear   = clr;
        bus.data_in = d;
        @(posedge clk);
        cyc++;
        if (!rst_n || clr) begin
            for (int t = cyc; t <= cyc + LVL; t++) sv[t] = 1'b0;
        end else if (en) begin
            ref_sum(d, s, f);
            sv[cyc+LVL-1] = 1'b1;
            ss[cyc+LVL-1] = s;
            sf[cyc+LVL-1] = f;
        end
        #1;
        check_out("model");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [DW-1:0] d;
        int            ops [NUM_IN];
        int            mode;
        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int t = 0; t < 8192; t++) begin
            sv[t] = 1'b0;
            ss[t] = 0;
            sf[t] = 1'b0;
        end

        tbl[0].name = "all_one";
        tbl[0].ops  = '{1, 1, 1, 1, 1, 1, 1, 1};
        tbl[0].exp  = 8;
        tbl[0].sat  = 1'b0;
        tbl[1].name = "mixed";
        tbl[1].ops  = '{-5, 3, -1000000, 7, 0, 1, -1, 2};
        tbl[1].exp  = -999993;
        tbl[1].sat  = 1'b0;
        tbl[2].name = "min";
        tbl[2].ops  = '{-1048576, -1048576, -1048576, -1048576,
                        -1048576, -1048576, -1048576, -1048576};
        tbl[3].name = "max";
        tbl[3].ops  = '{1048575, 1048575, 1048575, 1048575,
                        1048575, 1048575, 1048575, 1048575};
`ifdef ADDER_TREE_SAT_EN
        tbl[2].exp  = -2097152;
        tbl[2].sat  = 1'b1;
        tbl[3].exp  = 2097151;
        tbl[3].sat  = 1'b1;
`else
        tbl[2].exp  = -8388608;
        tbl[2].sat  = 1'b0;
        tbl[3].exp  = 8388600;
        tbl[3].sat  = 1'b0;
`endif

        rst_n       = 1'b0;
        bus.enable  = 1'b0;
        bus.clear   = 1'b0;
        bus.data_in = '0;
        #2;
        chk("rst.done", longint'(bus.done), 0);
        chk("rst.out", longint'($signed(bus.output1)), 0);
        chk("rst.sat", longint'(bus.sat_flag), 0);
        idle(2);
        rst_n = 1'b1;

        // Table vectors: one enable, result exactly at the third edge.
        foreach (tbl[v]) begin
            step(1'b1, 1'b0, pack(tbl[v].ops));
            chk({tbl[v].name, ".pre0"}, longint'(bus.done), 0);
            idle(1);
            chk({tbl[v].name, ".pre1"}, longint'(bus.done), 0);
            idle(1);
            chk({tbl[v].name, ".done"}, longint'(bus.done), 1);
            chk({tbl[v].name, ".out"},
                longint'($signed(bus.output1)), tbl[v].exp);
            chk({tbl[v].name, ".sat"},
                longint'(bus.sat_flag), longint'(tbl[v].sat));
            idle(1);
            chk({tbl[v].name, ".post"}, longint'(bus.done), 0);
            chk({tbl[v].name, ".zero"},
                longint'($signed(bus.output1)), 0);
        end

        // Back-to-back sets 1..4 give four consecutive done pulses.
        step(1'b1, 1'b0, fill(1));
        step(1'b1, 1'b0, fill(2));
        step(1'b1, 1'b0, fill(3));
        chk("b2b.out0", longint'($signed(bus.output1)), 8);
        step(1'b1, 1'b0, fill(4));
        chk("b2b.out1", longint'($signed(bus.output1)), 16);
        idle(1);
        chk("b2b.out2", longint'($signed(bus.output1)), 24);
        idle(1);
        chk("b2b.out3", longint'($signed(bus.output1)), 32);
        idle(1);
        chk("b2b.end", longint'(bus.done), 0);

        // Clear one cycle after enable kills the set.
        step(1'b1, 1'b0, fill(5));
        step(1'b0, 1'b1, '0);
        idle(1);
        chk("clr.kill", longint'(bus.done), 0);
        idle(2);
        // Enable together with clear is ignored; next one is accepted.
        step(1'b1, 1'b1, fill(6));
        step(1'b1, 1'b0, fill(7));
        chk("clr.ign", longint'(bus.done), 0);
        idle(1);
        chk("clr.ign2", longint'(bus.done), 0);
        idle(1);
        chk("clr.acc", longint'($signed(bus.output1)), 56);

        // Asynchronous reset in the middle of a stream.
        step(1'b1, 1'b0, fill(9));
        step(1'b1, 1'b0, fill(10));
        step(1'b1, 1'b0, fill(11));
        chk("ar.pre", longint'(bus.done), 1);
        rst_n = 1'b0;
        #1;
        chk("ar.done", longint'(bus.done), 0);
        chk("ar.out", longint'($signed(bus.output1)), 0);
        chk("ar.sat", longint'(bus.sat_flag), 0);
        idle(2);
        rst_n = 1'b1;
        step(1'b1, 1'b0, fill(1));
        idle(1);
        chk("ar.wait", longint'(bus.done), 0);
        idle(1);
        chk("ar.lat", longint'(bus.done), 1);
        chk("ar.res", longint'($signed(bus.output1)), 8);
        idle(2);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            mode = $urandom_range(0, 9);
            for (int i = 0; i < NUM_IN; i++) begin
                if (mode == 0)      ops[i] = 1048575;
                else if (mode == 1) ops[i] = -1048576;
                else                ops[i] = int'($urandom);
            end
            d = pack(ops);
            step($urandom_range(0, 9) < 7,
                 $urandom_range(0, 24) == 0, d);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_tree_pipe.md
ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

Interface
REQ-001 Parameter: DATA_W, 21, signed width of each input operand.
REQ-002 Parameter: NUM_IN, 8, number of operands; SHALL be a power of two, 2..16.
REQ-003 Parameter: SAT_W, 22, signed width the result is clamped to when saturation is compiled in; SAT_W <= FULL_W.
REQ-004 Derived constants: LVL = log2(NUM_IN); FULL_W = DATA_W + LVL.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  operand set on data_in is valid this cycle.
REQ-008 clear  input  1  synchronous pipeline flush.
REQ-009 data_in  input  NUM_IN*DATA_W  packed two's-complement operands; operand i occupies bits [i*DATA_W +: DATA_W].
REQ-010 output1  output  FULL_W  signed sum of all operands of one set.
REQ-011 done  output  1  output1 is valid this cycle.
REQ-012 sat_flag  output  1  output1 was clamped this cycle.

Function
REQ-013 The block SHALL be a binary reduction tree of LVL registered levels; level k SHALL hold NUM_IN/2^(k+1) partial sums of width DATA_W+k+1.
REQ-014 Each adder SHALL sign-extend both operands by one bit before adding; no intermediate overflow is possible.
REQ-015 Latency SHALL be exactly LVL cycles: an enable sampled at edge n SHALL produce done=1 and the sum at edge n+LVL-1, i.e. visible for the cycle following that edge.
REQ-016 Throughput SHALL be one operand set per cycle; back-to-back enables SHALL yield back-to-back done pulses in order.
REQ-017 A valid bit SHALL travel with each level; a level whose incoming valid is 0 SHALL load 0 into its partial sums and valid.
REQ-018 Consequently, output1 SHALL be 0 whenever done is 0.
REQ-019 clear=1 at an edge SHALL zero all levels and valid bits; enable in that same cycle SHALL be ignored; done SHALL be 0 in the following cycle.
REQ-020 An enable one cycle after clear SHALL be accepted normally.
REQ-021 NUM_IN=2 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-022 rst_n low SHALL asynchronously force all partial sums, output1, done and sat_flag to 0, including sets in flight.
REQ-023 Deassertion SHALL take effect at the first rising clk edge with rst_n high; enable sampled at that edge SHALL be accepted.

Configuration
REQ-024 Macro ADDER_TREE_SAT_EN SHALL control output saturation.
REQ-025 Defined: the final level SHALL clamp the sum to [-2^(SAT_W-1), 2^(SAT_W-1)-1], sign-extend it to FULL_W, and assert sat_flag with done when clamping occurred; latency is unchanged.
REQ-026 Undefined: output1 SHALL be the full-precision sum, and sat_flag SHALL be tied to 0.

Structure
REQ-027 A shared package adder_tree_pkg SHALL hold a clog2 function, the FULL_W derivation and the saturate helper.
REQ-028 One pipeline level SHALL be a sub-module adder_tree_level, parametrised by operand count and input width, and instantiated LVL times in a generate loop.

Verification
REQ-029 DATA_W=21, NUM_IN=8: a single enable with all operands 1 -> done high exactly 3 cycles later with output1=8; done low before and after.
REQ-030 Mixed signs: operands {-5,3,-1000000,7,0,1,-1,2} on enable -> output1 = -999993 after 3 cycles.
REQ-031 Four consecutive enables with all operands equal to 1, 2, 3, 4 respectively -> done high for four consecutive cycles with outputs 8, 16, 24, 32.
REQ-032 Extremes without the macro: all operands -2^20 -> output1 = -2^23; all operands 2^20-1 -> output1 = 8*(2^20-1).
REQ-033 Extremes with ADDER_TREE_SAT_EN and SAT_W=22: all operands 2^20-1 -> output1 = 2^21-1 and sat_flag=1; all operands 1 -> sat_flag=0.
REQ-034 Interruptions: clear asserted one cycle after an enable -> no done pulse; rst_n pulsed low mid-stream -> all outputs 0 immediately, and the next enable completes with correct latency.
